// File: rtl/mfi_pkg.sv
// mfi_pkg -- shared definitions for the MFI retirement trace buffer.
//   mfi_state_e : capture FSM states (IDLE / CAPTURE / FROZEN)
//   mfi_rec_t   : one captured retirement record (inst, pc, trap, seq)
//   MFI_*_W     : field widths used by the trace buffer and its storage
//   sat_inc16   : saturating increment for the 16-bit drop counter
package mfi_pkg;

  localparam int MFI_INST_W    = 32;
  localparam int MFI_PC_W      = 32;
  // The record struct cannot be parameterized, so the seq field is sized
  // for the widest supported SEQ_W; narrower counters are zero-extended.
  localparam int MFI_SEQ_MAX_W = 32;
  localparam int MFI_DROP_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } mfi_state_e;

  typedef struct packed {
    logic [MFI_INST_W-1:0]    inst;
    logic [MFI_PC_W-1:0]      pc;
    logic                     trap;
    logic [MFI_SEQ_MAX_W-1:0] seq;
  } mfi_rec_t;

  localparam int MFI_REC_W = $bits(mfi_rec_t);

  function automatic logic [MFI_DROP_W-1:0] sat_inc16(input logic [MFI_DROP_W-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mfi_fifo.sv
// mfi_fifo -- generic synchronous FIFO.
//   clk, reset_n     : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  : write request and data; ignored when full unless a
//                      pop happens in the same cycle
//   pop              : read request; ignored when empty
//   pop_data         : head entry, driven to zero while empty
//   full, empty      : derived from pointers carrying one extra wrap bit
module mfi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot on the same edge, so a full FIFO can take a
  // push alongside it; a push at empty cannot feed a same-cycle pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Storage is registered; zeroing while empty keeps the outputs at their
  // reset values without having to clear the array.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mfi_trace_buffer.sv
// mfi_trace_buffer -- captures core retirements (MFI) into a FIFO for a
// downstream consumer, numbering each offered record and counting drops.
//   clk, reset_n           : clock, asynchronous active-low reset
//   arm                    : level, capture enable
//   mfi_valid/trap/inst/pc_rdata : retirement interface from the core
//   out_valid/out_ready    : head-record handshake
//   out_inst/pc/trap/seq   : head record fields
//   drop_count             : saturating count of records lost to a full FIFO
//   state                  : current FSM state for debug
module mfi_trace_buffer
  import mfi_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SEQ_W          = 16,
  parameter bit FREEZE_ON_TRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  mfi_valid,
  input  logic                  mfi_trap,
  input  logic [MFI_INST_W-1:0] mfi_inst,
  input  logic [MFI_PC_W-1:0]   mfi_pc_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MFI_INST_W-1:0] out_inst,
  output logic [MFI_PC_W-1:0]   out_pc,
  output logic                  out_trap,
  output logic [SEQ_W-1:0]      out_seq,
  output logic [MFI_DROP_W-1:0] drop_count,
  output logic [1:0]            state
);

  mfi_state_e            state_reg, state_next;
  logic [SEQ_W-1:0]      seq_reg, seq_next;
  logic [MFI_DROP_W-1:0] drop_reg, drop_next;

  logic     offered;
  logic     pop_fire;
  logic     write_en;
  logic     dropped;
  logic     fifo_full;
  logic     fifo_empty;
  mfi_rec_t push_rec;
  mfi_rec_t pop_rec;

  assign offered  = (state_reg == ST_CAPTURE) && mfi_valid;
  assign pop_fire = out_valid && out_ready;
  assign write_en = offered && (!fifo_full || pop_fire);
  assign dropped  = offered && !write_en;

  always_comb begin
    push_rec      = '0;
    push_rec.inst = mfi_inst;
    push_rec.pc   = mfi_pc_rdata;
    push_rec.trap = mfi_trap;
    push_rec.seq  = MFI_SEQ_MAX_W'(seq_reg);
  end

  mfi_fifo #(
    .WIDTH (MFI_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (write_en),
    .push_data (push_rec),
    .pop       (pop_fire),
    .pop_data  (pop_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_inst   = pop_rec.inst;
  assign out_pc     = pop_rec.pc;
  assign out_trap   = pop_rec.trap;
  assign out_seq    = SEQ_W'(pop_rec.seq);
  assign drop_count = drop_reg;
  assign state      = state_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      seq_reg   <= '0;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      seq_reg   <= seq_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    seq_next   = seq_reg;
    drop_next  = drop_reg;

    // Records are only offered in CAPTURE, so the numbering step never
    // collides with the restart to zero on entry from IDLE.
    if (offered) seq_next = seq_reg + SEQ_W'(1);
    if (dropped) drop_next = sat_inc16(drop_reg);

    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          state_next = ST_CAPTURE;
          seq_next   = '0;
        end
      end
      ST_CAPTURE: begin
        // The trapping record itself is offered this cycle; capture stops
        // from the next cycle on.
        if (!arm)
          state_next = ST_IDLE;
        else if (FREEZE_ON_TRAP && offered && mfi_trap)
          state_next = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (!arm) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mfi_trace_buffer.sv
module tb_mfi_trace_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, mfi_valid, mfi_trap, out_ready;
  logic [31:0] mfi_inst, mfi_pc_rdata;
  logic        out_valid, out_trap;
  logic [31:0] out_inst, out_pc;
  logic [15:0] out_seq, drop_count;
  logic [1:0]  state;

  logic        arm2, valid2, ready2;
  logic        out_valid2, out_trap2;
  logic [31:0] out_inst2, out_pc2;
  logic [3:0]  out_seq2;
  logic [15:0] drop_count2;
  logic [1:0]  state2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mfi_trace_buffer #(.DEPTH(8), .SEQ_W(16), .FREEZE_ON_TRAP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .mfi_valid(mfi_valid),
    .mfi_trap(mfi_trap), .mfi_inst(mfi_inst), .mfi_pc_rdata(mfi_pc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_trap(out_trap), .out_seq(out_seq),
    .drop_count(drop_count), .state(state)
  );

  mfi_trace_buffer #(.DEPTH(8), .SEQ_W(4), .FREEZE_ON_TRAP(1'b1)) dut_w4 (
    .clk(clk), .reset_n(reset_n), .arm(arm2), .mfi_valid(valid2),
    .mfi_trap(mfi_trap), .mfi_inst(mfi_inst), .mfi_pc_rdata(mfi_pc_rdata),
    .out_valid(out_valid2), .out_ready(ready2), .out_inst(out_inst2),
    .out_pc(out_pc2), .out_trap(out_trap2), .out_seq(out_seq2),
    .drop_count(drop_count2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int drain_exp [8];

    reset_n = 1'b0; arm = 1'b0; mfi_valid = 1'b0; mfi_trap = 1'b0; out_ready = 1'b0;
    mfi_inst = 32'h0000_0013; mfi_pc_rdata = '0;
    arm2 = 1'b0; valid2 = 1'b0; ready2 = 1'b0;
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    check("rst_seq",   32'(out_seq), 32'd0);
    check("rst_inst",  out_inst, 32'd0);
    check("rst_pc",    out_pc, 32'd0);
    check("rst_trap",  32'(out_trap), 32'd0);
    #9 reset_n = 1'b1;
    tick();
    check("idle_no_arm", 32'(state), 32'd0);

    // Three retirements streamed through with out_ready held high.
    arm = 1'b1;
    tick();
    check("arm_capture", 32'(state), 32'd1);
    out_ready = 1'b1; mfi_valid = 1'b1; mfi_pc_rdata = 32'h0;
    check("no_bypass", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s3_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("s3_seq%0d", i), 32'(out_seq), 32'(i));
      check($sformatf("s3_pc%0d", i), out_pc, 32'(i * 4));
      check($sformatf("s3_inst%0d", i), out_inst, 32'h0000_0013);
      mfi_pc_rdata = 32'((i + 1) * 4);
    end
    mfi_valid = 1'b0;
    tick();
    check("s3_empty", 32'(out_valid), 32'd0);

    // Overflow: 10 retirements into 8 entries with the consumer stalled.
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mfi_valid = 1'b1; mfi_pc_rdata = 32'(i * 4);
      tick();
    end
    mfi_valid = 1'b0;
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_valid", 32'(out_valid), 32'd1);
    check("ovf_head_seq", 32'(out_seq), 32'd0);

    // Full FIFO with a pop and a retirement in the same cycle (seq 10).
    out_ready = 1'b1; mfi_valid = 1'b1; mfi_pc_rdata = 32'h100;
    tick();
    mfi_valid = 1'b0;
    check("full_pp_drop", 32'(drop_count), 32'd2);
    drain_exp = '{1, 2, 3, 4, 5, 6, 7, 10};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_seq%0d", k), 32'(out_seq), 32'(drain_exp[k]));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Freeze on the third retirement (seq 2).
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mfi_valid = 1'b1; mfi_trap = (i == 2); mfi_pc_rdata = 32'h200 + 32'(i * 4);
      tick();
      if (i == 2) check("frz_state", 32'(state), 32'd2);
    end
    mfi_valid = 1'b0; mfi_trap = 1'b0;
    check("frz_hold", 32'(state), 32'd2);
    check("frz_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("frz_seq%0d", k), 32'(out_seq), 32'(k));
      check($sformatf("frz_trap%0d", k), 32'(out_trap), (k == 2) ? 32'd1 : 32'd0);
      tick();
    end
    check("frz_only3", 32'(out_valid), 32'd0);
    arm = 1'b0; tick();
    check("frz_to_idle", 32'(state), 32'd0);
    arm = 1'b1; tick();
    check("rearm_state", 32'(state), 32'd1);
    mfi_valid = 1'b1; tick();
    mfi_valid = 1'b0;
    check("rearm_seq", 32'(out_seq), 32'd0);
    check("rearm_valid", 32'(out_valid), 32'd1);
    tick();
    check("rearm_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with five records queued.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mfi_valid = 1'b1; tick();
    end
    mfi_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_drop",  32'(drop_count), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    #2 reset_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(state), 32'd0);
    tick();
    check("post_rst_arm", 32'(state), 32'd1);
    arm = 1'b0;
    tick();

    // SEQ_W=4 instance: 20 records stream through, seq wraps 15 -> 0.
    arm2 = 1'b1; tick();
    ready2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid2 = 1'b1; tick();
      check($sformatf("w4_seq%0d", i), 32'(out_seq2), 32'(i % 16));
    end
    valid2 = 1'b0;
    tick();
    check("w4_empty", 32'(out_valid2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
